// File: rtl/tree_pkg.sv
// ---------------------------------------------------------------------------
// tree_pkg
// Shared definitions for the decision-tree node memory and its host loader.
//   node_t        : one decoded tree node (also consumed by the inference engine)
//   TREE_HDR      : frame header byte
//   err_code_e    : loader status codes
//   load_state_e  : loader FSM states
//   B1_*/B2_*     : bit positions inside the 3-byte node record
// ---------------------------------------------------------------------------
package tree_pkg;

  localparam logic [7:0] TREE_HDR = 8'hA5;

  // Child indices travel as 6 bits on the link regardless of tree size.
  localparam int IDX_BITS = 6;

  // Node counts go up to 64, so one extra bit over the index width.
  localparam int CNT_W = IDX_BITS + 1;

  localparam int B1_LEAF_BIT = 7;
  localparam int B1_LT_BIT   = 6;
  localparam int B2_ACT_HI   = 7;
  localparam int B2_ACT_LO   = 6;
  localparam int IDX_HI      = IDX_BITS - 1;

  typedef struct packed {
    logic                is_leaf;
    logic                less_than;
    logic [7:0]          threshold;
    logic [IDX_BITS-1:0] left_idx;
    logic [IDX_BITS-1:0] right_idx;
    logic [1:0]          action;
  } node_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_COUNT = 2'b01,
    ERR_CHILD = 2'b10,
    ERR_CSUM  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
    S_CHK,
    S_FIN
  } load_state_e;

endpackage

// File: rtl/tree_record_decode.sv
// ---------------------------------------------------------------------------
// tree_record_decode
// Purely combinational decoder for one 3-byte node record.
//   b0, b1, b2  in  record bytes (threshold, flags/left, action/right)
//   node_count  in  number of nodes in the current frame
//   node        out decoded node_t
//   bad_idx     out internal node whose child index is out of range
// ---------------------------------------------------------------------------
module tree_record_decode
  import tree_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic [7:0]       b0,
  input  logic [7:0]       b1,
  input  logic [7:0]       b2,
  input  logic [CNT_W-1:0] node_count,
  output node_t            node,
  output logic             bad_idx
);

  logic left_bad;
  logic right_bad;

  // Split the record into fields. A child index is unusable if it points past
  // the last node of this frame or uses bits the tree's address port lacks;
  // leaves carry no children, so their index fields are never judged.
  always_comb begin
    node           = '0;
    node.threshold = b0;
    node.is_leaf   = b1[B1_LEAF_BIT];
    node.less_than = b1[B1_LT_BIT];
    node.left_idx  = b1[IDX_HI:0];
    node.action    = b2[B2_ACT_HI:B2_ACT_LO];
    node.right_idx = b2[IDX_HI:0];

    left_bad  = ({1'b0, node.left_idx} >= node_count) ||
                ((node.left_idx >> ADDR_WIDTH) != '0);
    right_bad = ({1'b0, node.right_idx} >= node_count) ||
                ((node.right_idx >> ADDR_WIDTH) != '0);
    bad_idx   = !node.is_leaf && (left_bad || right_bad);
  end

endmodule

// File: rtl/tree_loader.sv
// ---------------------------------------------------------------------------
// tree_loader
// Host-side writer for the decision-tree node memory. Consumes a framed byte
// stream (A5, count N, N x 3-byte records [, checksum]) and issues one node
// write per record on the tree's software write port, then reports status.
//
// Optional feature macro: TREE_LOADER_CHECKSUM_EN
//   defined   : a trailing XOR checksum byte is expected and verified
//   undefined : no checksum byte, frame ends after the last record
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream from the host link
//   sw_we, sw_addr, sw_data_*  node write port (one-cycle strobe)
//   load_busy                frame in progress
//   load_done / load_err     one-cycle frame result pulses
//   err_code                 00 none, 01 count, 10 child index, 11 checksum
//   tree_valid               tree fully and correctly loaded
// ---------------------------------------------------------------------------
module tree_loader
  import tree_pkg::*;
#(
  parameter int MAX_NODES  = 64,
  parameter int ADDR_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sw_we,
  output logic [ADDR_WIDTH-1:0] sw_addr,
  output logic                  sw_data_is_leaf,
  output logic                  sw_data_less_than,
  output logic [7:0]            sw_data_threshold,
  output logic [ADDR_WIDTH-1:0] sw_data_left_idx,
  output logic [ADDR_WIDTH-1:0] sw_data_right_idx,
  output logic [1:0]            sw_data_action,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code,
  output logic                  tree_valid
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_NODES);

  load_state_e      state_q;
  load_state_e      state_d;
  err_code_e        err_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] node_cnt_q;
  logic [7:0]       b0_q;
  logic [7:0]       b1_q;
  logic             hs;
  logic             count_ok;
  logic             last_node;
  node_t            node;
  logic             bad_idx;
`ifdef TREE_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign hs        = in_valid && in_ready;
  assign count_ok  = (in_data != 8'd0) && (in_data <= MAX_CNT);
  assign last_node = (node_cnt_q + 1'b1) == count_q;
  assign err_code  = err_q;

  // The third record byte is decoded straight off the link so that the whole
  // node can be registered onto the write port in the B2 handshake cycle.
  tree_record_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .b0         (b0_q),
    .b1         (b1_q),
    .b2         (in_data),
    .node_count (count_q),
    .node       (node),
    .bad_idx    (bad_idx)
  );

  // State register. Reset always lands back in IDLE, abandoning any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the ready handshake. The link is stalled only for
  // the single FIN cycle, where the result is being reported, and in reset.
  always_comb begin
    state_d  = state_q;
    in_ready = !rst && (state_q != S_FIN);
    unique case (state_q)
      S_IDLE: begin
        if (hs && (in_data == TREE_HDR)) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (hs) begin
          state_d = count_ok ? S_B0 : S_IDLE;
        end
      end
      S_B0: begin
        if (hs) begin
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (hs) begin
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (hs) begin
`ifdef TREE_LOADER_CHECKSUM_EN
          state_d = last_node ? S_CHK : S_B0;
`else
          state_d = last_node ? S_FIN : S_B0;
`endif
        end
      end
      S_CHK: begin
        if (hs) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: byte capture, node write port, running checksum and status.
  // The error register is sticky within a frame so the first problem found
  // is the one reported; a bad child index still lets the frame run to its
  // end so the host and loader stay in step on byte boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_we             <= 1'b0;
      sw_addr           <= '0;
      sw_data_is_leaf   <= 1'b0;
      sw_data_less_than <= 1'b0;
      sw_data_threshold <= '0;
      sw_data_left_idx  <= '0;
      sw_data_right_idx <= '0;
      sw_data_action    <= '0;
      load_busy         <= 1'b0;
      load_done         <= 1'b0;
      load_err          <= 1'b0;
      tree_valid        <= 1'b0;
      err_q             <= ERR_NONE;
      count_q           <= '0;
      node_cnt_q        <= '0;
      b0_q              <= '0;
      b1_q              <= '0;
`ifdef TREE_LOADER_CHECKSUM_EN
      csum_q            <= '0;
`endif
    end else begin
      sw_we     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hs && (in_data == TREE_HDR)) begin
            err_q      <= ERR_NONE;
            tree_valid <= 1'b0;
            load_busy  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (hs) begin
            if (!count_ok) begin
              err_q     <= ERR_COUNT;
              load_err  <= 1'b1;
              load_busy <= 1'b0;
            end else begin
              count_q    <= in_data[CNT_W-1:0];
              node_cnt_q <= '0;
`ifdef TREE_LOADER_CHECKSUM_EN
              csum_q     <= in_data;
`endif
            end
          end
        end
        S_B0: begin
          if (hs) begin
            b0_q <= in_data;
`ifdef TREE_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        S_B1: begin
          if (hs) begin
            b1_q <= in_data;
`ifdef TREE_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        S_B2: begin
          if (hs) begin
            sw_we             <= 1'b1;
            sw_addr           <= node_cnt_q[ADDR_WIDTH-1:0];
            sw_data_is_leaf   <= node.is_leaf;
            sw_data_less_than <= node.less_than;
            sw_data_threshold <= node.threshold;
            sw_data_left_idx  <= node.left_idx[ADDR_WIDTH-1:0];
            sw_data_right_idx <= node.right_idx[ADDR_WIDTH-1:0];
            sw_data_action    <= node.action;
            node_cnt_q        <= node_cnt_q + 1'b1;
            if (bad_idx && (err_q == ERR_NONE)) begin
              err_q <= ERR_CHILD;
            end
`ifdef TREE_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end
        end
        S_CHK: begin
`ifdef TREE_LOADER_CHECKSUM_EN
          if (hs && (in_data != csum_q) && (err_q == ERR_NONE)) begin
            err_q <= ERR_CSUM;
          end
`endif
        end
        S_FIN: begin
          load_busy <= 1'b0;
          if (err_q != ERR_NONE) begin
            load_err <= 1'b1;
          end else begin
            load_done  <= 1'b1;
            tree_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_loader.sv
// ---------------------------------------------------------------------------
// tb_tree_loader
// Scoreboard bench for tree_loader. Stimulus pushes hand-written expected
// node writes and frame results into queues; a negedge monitor pops and
// compares whenever the DUT strobes sw_we or a load_done/load_err pulse.
// Honors TREE_LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_tree_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sw_we;
  logic [AW-1:0] sw_addr;
  logic          sw_data_is_leaf;
  logic          sw_data_less_than;
  logic [7:0]    sw_data_threshold;
  logic [AW-1:0] sw_data_left_idx;
  logic [AW-1:0] sw_data_right_idx;
  logic [1:0]    sw_data_action;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [1:0]    err_code;
  logic          tree_valid;

  tree_loader #(
    .MAX_NODES  (64),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .sw_we             (sw_we),
    .sw_addr           (sw_addr),
    .sw_data_is_leaf   (sw_data_is_leaf),
    .sw_data_less_than (sw_data_less_than),
    .sw_data_threshold (sw_data_threshold),
    .sw_data_left_idx  (sw_data_left_idx),
    .sw_data_right_idx (sw_data_right_idx),
    .sw_data_action    (sw_data_action),
    .load_busy         (load_busy),
    .load_done         (load_done),
    .load_err          (load_err),
    .err_code          (err_code),
    .tree_valid        (tree_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] addr;
    logic       leaf;
    logic       lt;
    logic [7:0] thr;
    logic [5:0] l;
    logic [5:0] r;
    logic [1:0] act;
  } wr_t;

  // is_err, expected code, expected tree_valid, cycles from last byte handshake
  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic       tv;
    logic [1:0] lat;
  } st_t;

  wr_t        wr_q[$];
  st_t        st_q[$];
  logic [7:0] frame_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = 0;

  wr_t mon_wr_got;
  wr_t mon_wr_exp;
  st_t mon_st_got;
  st_t mon_st_exp;

  // Cycle counter and the cycle of the most recent accepted byte, used to
  // measure result-pulse latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      last_hs <= cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: compares every write strobe and every result pulse against the
  // scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (sw_we) begin
        mon_wr_got = {sw_addr, sw_data_is_leaf, sw_data_less_than, sw_data_threshold,
                      sw_data_left_idx, sw_data_right_idx, sw_data_action};
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write got=%0h expected=none", mon_wr_got);
        end else begin
          mon_wr_exp = wr_q.pop_front();
          checkOutput("node_write", 32'(mon_wr_got), 32'(mon_wr_exp));
        end
      end
      if (load_done || load_err) begin
        mon_st_got = {load_err, err_code, tree_valid, 2'(cyc - last_hs)};
        if (st_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_status got=%0h expected=none", mon_st_got);
        end else begin
          mon_st_exp = st_q.pop_front();
          checkOutput("pulse_kind", {30'd0, load_err, load_done},
                      mon_st_exp.is_err ? 32'd2 : 32'd1);
          checkOutput("frame_status", 32'(mon_st_got), 32'(mon_st_exp));
        end
      end
    end
  end

  // Called at posedge+1 with in_valid low; leaves in_valid low at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout got=ready_low expected=ready_high");
    end
  endtask

  task automatic applyStimulus(input bit gaps, input int idle_after);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
    frame_q.delete();
    repeat (idle_after) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void add_rec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    frame_q.push_back(b0);
    frame_q.push_back(b1);
    frame_q.push_back(b2);
  endfunction

  // XOR over count and records, optionally corrupted; no-op without checksum.
  function automatic void add_csum(input logic [7:0] flip);
`ifdef TREE_LOADER_CHECKSUM_EN
    logic [7:0] x;
    int start;
    start = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (frame_q[i] == 8'hA5 && start == 0) start = i + 1;
    end
    x = 8'h00;
    for (int i = start; i < frame_q.size(); i++) x = x ^ frame_q[i];
    frame_q.push_back(x ^ flip);
`else
    if (flip != 8'h00) frame_q.push_back(8'h00);
`endif
  endfunction

  // Frame A: internal root (lt, left 1, right 2), two leaves; leaf 2 carries
  // out-of-range index fields that must be ignored because it is a leaf.
  function automatic void frame_a(input logic [7:0] flip);
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h03);
    add_rec(8'h80, 8'h41, 8'h02);
    add_rec(8'h11, 8'h80, 8'h40);
    add_rec(8'h00, 8'hBF, 8'hBF);
    add_csum(flip);
  endfunction

  function automatic void expect_a_writes();
    wr_q.push_back(wr_t'{6'd0, 1'b0, 1'b1, 8'h80, 6'd1,  6'd2,  2'd0});
    wr_q.push_back(wr_t'{6'd1, 1'b1, 1'b0, 8'h11, 6'd0,  6'd0,  2'd1});
    wr_q.push_back(wr_t'{6'd2, 1'b1, 1'b0, 8'h00, 6'd63, 6'd63, 2'd2});
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, sampled while rst is still high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_sw_we", 32'(sw_we), 32'd0);
    checkOutput("rst_busy", 32'(load_busy), 32'd0);
    checkOutput("rst_tree_valid", 32'(tree_valid), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_sw_addr", 32'(sw_addr), 32'd0);
    checkOutput("rst_threshold", 32'(sw_data_threshold), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] clean frame A");
    frame_a(8'h00);
    expect_a_writes();
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b0, 4);
    checkOutput("a_tree_valid", 32'(tree_valid), 32'd1);
    checkOutput("a_busy_after", 32'(load_busy), 32'd0);

    $display("[TB] bad counts 0x00 and 0x41");
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h00);
    st_q.push_back(st_t'{1'b1, 2'd1, 1'b0, 2'd1});
    applyStimulus(1'b0, 4);
    checkOutput("cnt0_err_code_held", 32'(err_code), 32'd1);
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h41);
    st_q.push_back(st_t'{1'b1, 2'd1, 1'b0, 2'd1});
    applyStimulus(1'b0, 4);
    checkOutput("cnt41_busy", 32'(load_busy), 32'd0);
    frame_a(8'h00);
    expect_a_writes();
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b0, 4);

    $display("[TB] bad child index");
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h03);
    add_rec(8'h20, 8'h05, 8'h01);
    add_rec(8'h11, 8'h80, 8'h40);
    add_rec(8'h00, 8'hBF, 8'hBF);
    add_csum(8'h00);
    wr_q.push_back(wr_t'{6'd0, 1'b0, 1'b0, 8'h20, 6'd5,  6'd1,  2'd0});
    wr_q.push_back(wr_t'{6'd1, 1'b1, 1'b0, 8'h11, 6'd0,  6'd0,  2'd1});
    wr_q.push_back(wr_t'{6'd2, 1'b1, 1'b0, 8'h00, 6'd63, 6'd63, 2'd2});
    st_q.push_back(st_t'{1'b1, 2'd2, 1'b0, 2'd2});
    applyStimulus(1'b0, 4);
    checkOutput("child_tree_valid", 32'(tree_valid), 32'd0);

`ifdef TREE_LOADER_CHECKSUM_EN
    $display("[TB] corrupted checksum");
    frame_a(8'h01);
    expect_a_writes();
    st_q.push_back(st_t'{1'b1, 2'd3, 1'b0, 2'd2});
    applyStimulus(1'b0, 4);
`else
    $display("[TB] frame A without checksum byte");
    frame_a(8'h00);
    expect_a_writes();
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b0, 4);
`endif

    $display("[TB] garbage then frame A with gaps");
    frame_q.push_back(8'h00);
    frame_q.push_back(8'hFF);
    frame_a(8'h00);
    expect_a_writes();
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b1, 4);
    checkOutput("gap_err_code", 32'(err_code), 32'd0);

    $display("[TB] reset after B1 of node 1");
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h03);
    add_rec(8'h80, 8'h41, 8'h02);
    frame_q.push_back(8'h11);
    frame_q.push_back(8'h80);
    wr_q.push_back(wr_t'{6'd0, 1'b0, 1'b1, 8'h80, 6'd1, 6'd2, 2'd0});
    applyStimulus(1'b0, 0);
    @(negedge clk);
    checkOutput("midframe_busy", 32'(load_busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(load_busy), 32'd0);
    checkOutput("abort_tree_valid", 32'(tree_valid), 32'd0);
    @(posedge clk);
    #1;
    frame_a(8'h00);
    expect_a_writes();
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b0, 4);

    $display("[TB] full 64-node frame of leaves");
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h40);
    for (int i = 0; i < 64; i++) begin
      add_rec(8'(i), 8'h80, {2'(i), 6'd0});
      wr_q.push_back(wr_t'{6'(i), 1'b1, 1'b0, 8'(i), 6'd0, 6'd0, 2'(i)});
    end
    add_csum(8'h00);
    st_q.push_back(st_t'{1'b0, 2'd0, 1'b1, 2'd2});
    applyStimulus(1'b0, 6);

    checkOutput("writes_all_seen", 32'(wr_q.size()), 32'd0);
    checkOutput("status_all_seen", 32'(st_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
